// File: rtl/key_press_emulator_if.sv
// Command and key-line bundle between a test controller (master) and the
// push-button emulator (slave).
interface key_press_emulator_if #(
   parameter int KEY_WIDTH = 2,
   parameter int HOLD_W    = 24
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [KEY_WIDTH-1:0] cmd_key;
   logic [HOLD_W-1:0]    cmd_hold;
   logic [KEY_WIDTH-1:0] key_data;
   logic                 busy;
   logic                 done;

   modport master (
      output cmd_valid, cmd_key, cmd_hold,
      input  cmd_ready, key_data, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_key, cmd_hold,
      output cmd_ready, key_data, busy, done
   );
endinterface

// File: rtl/key_press_emulator.sv
// Push-button emulator: drives active-low key lines through press bounce, hold,
// release bounce on command. Define KEY_EMU_ABORT_EN to add the abort input.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | lines released, cmd_ready high, waiting for a command
// S_PRESS   | press bounce: masked lines follow lfsr[0], last cycle low
// S_HOLD    | masked lines held low for max(cmd_hold,1) cycles
// S_RELEASE | release bounce: masked lines follow lfsr[0], last cycle high
// S_DONE    | one-cycle done pulse, lines released
module key_press_emulator #(
   parameter int KEY_WIDTH     = 2,
   parameter int HOLD_W        = 24,
   parameter int BOUNCE_CYCLES = 1000,
   parameter int TOGGLE_PERIOD = 16
) (
   input  logic clk,
   input  logic rst_n,
`ifdef KEY_EMU_ABORT_EN
   input  logic abort,
`endif
   key_press_emulator_if.slave kif
);

   localparam int PW = $clog2(BOUNCE_CYCLES);
   localparam int TW = (TOGGLE_PERIOD > 1) ? $clog2(TOGGLE_PERIOD) : 1;

   localparam logic [PW-1:0]     PHASE_LAST = PW'(BOUNCE_CYCLES - 1);
   localparam logic [PW-1:0]     PHASE_ONE  = PW'(1);
   localparam logic [TW-1:0]     TOG_LAST   = TW'(TOGGLE_PERIOD - 1);
   localparam logic [TW-1:0]     TOG_ONE    = TW'(1);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
   localparam logic [15:0]       LFSR_SEED  = 16'hACE1;
   localparam logic [15:0]       LFSR_TAPS  = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS,
      S_HOLD,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t               state;
   logic [15:0]          lfsr;
   logic [15:0]          lfsr_nxt;
   logic [KEY_WIDTH-1:0] mask;
   logic [PW-1:0]        phase_cnt;
   logic [TW-1:0]        tog_cnt;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [HOLD_W-1:0]    hold_ld;
   logic [KEY_WIDTH-1:0] key_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 abort_i;

`ifdef KEY_EMU_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
   assign hold_ld  = (kif.cmd_hold == '0) ? HOLD_ONE : kif.cmd_hold;

   assign kif.key_data  = key_q;
   assign kif.cmd_ready = ready_q;
   assign kif.busy      = busy_q;
   assign kif.done      = done_q;

   // lvl=1 releases every line; lvl=0 pulls only the masked lines low
   function automatic logic [KEY_WIDTH-1:0] drive(input logic [KEY_WIDTH-1:0] m,
                                                  input logic lvl);
      return lvl ? {KEY_WIDTH{1'b1}} : ~m;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         lfsr      <= LFSR_SEED;
         mask      <= '0;
         phase_cnt <= '0;
         tog_cnt   <= '0;
         hold_cnt  <= '0;
         key_q     <= '1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         lfsr   <= lfsr_nxt;
         done_q <= 1'b0;
         if (state != S_IDLE && abort_i) begin
            state   <= S_IDLE;
            key_q   <= '1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (kif.cmd_valid && ready_q) begin
                     mask     <= kif.cmd_key;
                     hold_cnt <= hold_ld;
                     ready_q  <= 1'b0;
                     busy_q   <= 1'b1;
                     if (kif.cmd_key == '0) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                     end else begin
                        state     <= S_PRESS;
                        key_q     <= drive(kif.cmd_key, lfsr[0]);
                        phase_cnt <= PHASE_LAST;
                        tog_cnt   <= TOG_LAST;
                     end
                  end
               end
               S_PRESS, S_RELEASE: begin
                  if (phase_cnt == '0) begin
                     if (state == S_PRESS) begin
                        state <= S_HOLD;
                        key_q <= drive(mask, 1'b0);
                     end else begin
                        state  <= S_DONE;
                        key_q  <= '1;
                        done_q <= 1'b1;
                     end
                  end else begin
                     phase_cnt <= phase_cnt - PHASE_ONE;
                     // final bounce cycle settles to the phase's end level
                     if (phase_cnt == PHASE_ONE)
                        key_q <= drive(mask, state == S_RELEASE);
                     else if (tog_cnt == '0)
                        key_q <= drive(mask, lfsr[0]);
                     if (tog_cnt == '0)
                        tog_cnt <= TOG_LAST;
                     else
                        tog_cnt <= tog_cnt - TOG_ONE;
                  end
               end
               S_HOLD: begin
                  if (hold_cnt <= HOLD_ONE) begin
                     state     <= S_RELEASE;
                     key_q     <= drive(mask, lfsr[0]);
                     phase_cnt <= PHASE_LAST;
                     tog_cnt   <= TOG_LAST;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_ONE;
                  end
               end
               S_DONE: begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state   <= S_IDLE;
                  key_q   <= '1;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_press_emulator.sv
// Randomized scoreboard bench for key_press_emulator: expected per-cycle line
// levels are derived from the phase rules and queued; a monitor compares each cycle.
`timescale 1ns/1ps
module tb_key_press_emulator;
   localparam int KW = 2, HW = 24, B = 64, T = 8, NCMD = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef KEY_EMU_ABORT_EN
   logic abort = 1'b0;
`endif

   key_press_emulator_if #(.KEY_WIDTH(KW), .HOLD_W(HW)) kif ();

   key_press_emulator #(
      .KEY_WIDTH(KW), .HOLD_W(HW), .BOUNCE_CYCLES(B), .TOGGLE_PERIOD(T)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
`ifdef KEY_EMU_ABORT_EN
      .abort(abort),
`endif
      .kif  (kif)
   );

   typedef struct {
      int          e;
      logic [KW-1:0] kd;
      logic        dn;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          edge_cnt = 0;
   int          next_free = 0;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // reference sequence: seeded by reset, one step per clock
   always @(posedge clk or negedge rst_n)
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_step(m_lfsr);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_cnt, act, expv);
      end
   endtask

   // Queue the expected {key_data, done} of every busy cycle of a command accepted at edge k.
   task automatic build_cmd(input int k, input logic [15:0] l0, input logic [KW-1:0] m,
                            input logic [HW-1:0] h, output int len);
      int   hp, total, c;
      bit   bits[0:1023];
      logic lvl;
      logic [15:0] l;
      exp_t x;
      hp = int'(h);
      if (hp == 0) hp = 1;
      if (m == '0) begin
         x.e = k; x.kd = '1; x.dn = 1'b1;
         exp_q.push_back(x);
         len = 1;
         return;
      end
      total = 2*B + hp + 1;
      l = l0;
      for (int j = 0; j < total; j++) begin
         bits[j] = l[0];
         l = lfsr_step(l);
      end
      for (int j = 0; j < total; j++) begin
         if (j < B) begin
            c = j;
            lvl = (c == B-1) ? 1'b0 : bits[c - c % T];
         end else if (j < B + hp) begin
            lvl = 1'b0;
         end else if (j < 2*B + hp) begin
            c = j - B - hp;
            lvl = (c == B-1) ? 1'b1 : bits[B + hp + c - c % T];
         end else begin
            lvl = 1'b1;
         end
         x.e  = k + j;
         x.kd = lvl ? {KW{1'b1}} : ~m;
         x.dn = (j == total - 1);
         exp_q.push_back(x);
      end
      len = total;
   endtask

   always @(negedge clk) begin : monitor
      exp_t x;
      logic [4:0] act, expv;
      if (rst_n) begin
         act = {kif.key_data, kif.busy, kif.cmd_ready, kif.done};
         while (exp_q.size() > 0 && exp_q[0].e < edge_cnt) begin
            x = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_cycle: expected entry for edge %0d never compared", x.e);
         end
         if (exp_q.size() > 0 && exp_q[0].e == edge_cnt) begin
            x = exp_q.pop_front();
            expv = {x.kd, 1'b1, 1'b0, x.dn};
         end else begin
            expv = {{KW{1'b1}}, 1'b0, 1'b1, 1'b0};
         end
         check("cycle{key,busy,ready,done}", {27'd0, act}, {27'd0, expv});
      end
   end

   task automatic set_payload(input int n);
      case (n)
         0:       begin kif.cmd_key = 2'b01; kif.cmd_hold = 24'd100; end
         1:       begin kif.cmd_key = 2'b00; kif.cmd_hold = 24'd7;   end
         2:       begin kif.cmd_key = 2'b11; kif.cmd_hold = 24'd0;   end
         3:       begin kif.cmd_key = 2'b10; kif.cmd_hold = 24'd1;   end
         default: begin
            kif.cmd_key  = KW'($urandom_range(0, 3));
            kif.cmd_hold = HW'($urandom_range(0, 120));
         end
      endcase
   endtask

   task automatic issue(input logic [KW-1:0] m, input logic [HW-1:0] h, output int k);
      int len;
      @(negedge clk);
      while (edge_cnt + 1 < next_free) @(negedge clk);
      kif.cmd_valid = 1'b1;
      kif.cmd_key   = m;
      kif.cmd_hold  = h;
      k = edge_cnt + 1;
      build_cmd(k, m_lfsr, m, h, len);
      next_free = k + len + 1;
      @(negedge clk);
      kif.cmd_valid = 1'b0;
   endtask

   initial begin
      int  ncmd, up, len, k_cur, len_cur, k;
      bit  acc_prev;
      kif.cmd_valid = 1'b0;
      kif.cmd_key   = '0;
      kif.cmd_hold  = '0;
      ncmd = 0; acc_prev = 0; k_cur = 0; len_cur = 0;
      repeat (3) @(negedge clk);
      check("in_reset", {27'd0, kif.key_data, kif.busy, kif.cmd_ready, kif.done}, 32'h1A);
      rst_n = 1'b1;
      #1;
      check("after_reset", {27'd0, kif.key_data, kif.busy, kif.cmd_ready, kif.done}, 32'h1A);
      next_free = edge_cnt + 1;

      while (ncmd < NCMD) begin
         @(negedge clk);
         up = edge_cnt + 1;
`ifdef KEY_EMU_ABORT_EN
         abort = 1'b0;
`endif
         if (acc_prev) begin
            kif.cmd_valid = ($urandom_range(0, 1) == 1);
            set_payload(ncmd);
         end else if (!kif.cmd_valid) begin
            kif.cmd_valid = ($urandom_range(0, 3) == 0);
            set_payload(ncmd);
         end else if (up < next_free && $urandom_range(0, 3) == 0) begin
            set_payload(ncmd);
         end
`ifdef KEY_EMU_ABORT_EN
         if (ncmd > 4 && up < next_free && edge_cnt >= k_cur &&
             edge_cnt - k_cur <= len_cur - 2 && $urandom_range(0, 299) == 0) begin
            abort = 1'b1;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].e > edge_cnt)
               void'(exp_q.pop_back());
            next_free = edge_cnt + 2;
         end else if (up >= next_free && $urandom_range(0, 7) == 0) begin
            abort = 1'b1;
         end
`endif
         if (kif.cmd_valid && up >= next_free) begin
            build_cmd(up, m_lfsr, kif.cmd_key, kif.cmd_hold, len);
            k_cur = up; len_cur = len;
            next_free = up + len + 1;
            ncmd++;
            acc_prev = 1;
         end else begin
            acc_prev = 0;
         end
      end

      @(negedge clk);
      kif.cmd_valid = 1'b0;
`ifdef KEY_EMU_ABORT_EN
      abort = 1'b0;
`endif
      // reset asynchronously in the middle of a long hold
      issue(2'b11, 24'd200, k);
      while (edge_cnt < k + B + 50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid_hold", {27'd0, kif.key_data, kif.busy, kif.cmd_ready, kif.done}, 32'h1A);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      next_free = edge_cnt + 1;
      issue(2'b10, 24'd5, k);
      while (edge_cnt < next_free + 3) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
